// File: rtl/nios_system_button_poller_pkg.sv
`default_nettype none
// ============================================================================
// Module   : nios_system_button_poller_pkg
// Purpose  : Shared types and helpers for the pushbutton poller.
//            - poll_state_t : poll FSM state encoding
//            - cntr_width() : counter width helper (ceil(log2(n)), never 0)
// Revision : 1.0 - initial release
// ============================================================================
package nios_system_button_poller_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    READ    = 2'd1,
    CAPTURE = 2'd2
  } poll_state_t;

  // Bits needed to hold values 0..value-1. The result is at least 1 so that
  // degenerate parameter choices still give a legal vector width.
  function automatic int cntr_width(input int value);
    int w;
    w = 1;
    while ((1 << w) < value) begin
      w++;
    end
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/nios_system_button_debounce.sv
`default_nettype none
// ============================================================================
// Module   : nios_system_button_debounce
// Purpose  : Debounces a stream of button samples. A new level is accepted
//            once DEBOUNCE_N consecutive identical samples have been seen
//            and the level differs from the current debounced value.
// Ports    : clk, reset_n      - clock, async active-low reset
//            sample_valid      - one-cycle strobe, sample is valid
//            sample            - raw button levels (active-low keys)
//            buttons           - debounced levels (1 = released)
//            pressed/released  - one-cycle pulses on accepted 1->0 / 0->1
// Revision : 1.0 - initial release
// ============================================================================
module nios_system_button_debounce
  import nios_system_button_poller_pkg::*;
#(
  parameter int DATA_W     = 4,
  parameter int DEBOUNCE_N = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] sample,
  output logic [DATA_W-1:0] buttons,
  output logic [DATA_W-1:0] pressed,
  output logic [DATA_W-1:0] released
);

  localparam int               CNT_W     = cntr_width(DEBOUNCE_N + 1);
  localparam logic [CNT_W-1:0] C_CNT_MAX = CNT_W'(DEBOUNCE_N);

  logic [DATA_W-1:0] r_cand;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_buttons;
  logic [DATA_W-1:0] r_pressed;
  logic [DATA_W-1:0] r_released;

  logic [DATA_W-1:0] w_cand_next;
  logic [CNT_W-1:0]  w_cnt_next;
  logic              w_accept;

  // Candidate tracking: a repeat of the candidate extends the run (saturating
  // at DEBOUNCE_N), anything else restarts the run with the new sample.
  always_comb begin
    w_cand_next = r_cand;
    w_cnt_next  = r_cnt;
    if (sample == r_cand) begin
      if (r_cnt != C_CNT_MAX) begin
        w_cnt_next = r_cnt + CNT_W'(1);
      end
    end else begin
      w_cand_next = sample;
      w_cnt_next  = CNT_W'(1);
    end
  end

  assign w_accept = sample_valid && (w_cnt_next == C_CNT_MAX) && (w_cand_next != r_buttons);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cand     <= '1;
      r_cnt      <= '0;
      r_buttons  <= '1;
      r_pressed  <= '0;
      r_released <= '0;
    end else begin
      // Pulses are single-cycle: cleared on every edge without an acceptance.
      r_pressed  <= '0;
      r_released <= '0;
      if (sample_valid) begin
        r_cand <= w_cand_next;
        r_cnt  <= w_cnt_next;
      end
      if (w_accept) begin
        r_buttons  <= w_cand_next;
        r_pressed  <= r_buttons & ~w_cand_next;
        r_released <= ~r_buttons & w_cand_next;
      end
    end
  end

  assign buttons  = r_buttons;
  assign pressed  = r_pressed;
  assign released = r_released;

endmodule
`default_nettype wire

// File: rtl/nios_system_button_poller.sv
`default_nettype none
// ============================================================================
// Module   : nios_system_button_poller
// Purpose  : Avalon-MM read master that polls the pushbutton PIO data
//            register every POLL_DIV+2 cycles and debounces the result,
//            giving fabric logic key levels and press/release pulses.
// Ports    : clk, reset_n        - clock, async active-low reset
//            enable              - polling enable
//            avm_address/read    - Avalon-MM read request (address fixed 0)
//            avm_readdata        - PIO data, valid the cycle after avm_read
//            buttons             - debounced key levels (1 = released)
//            pressed/released    - one-cycle change pulses per key
// Revision : 1.0 - initial release
// ============================================================================
module nios_system_button_poller
  import nios_system_button_poller_pkg::*;
#(
  parameter int POLL_DIV   = 50000,
  parameter int DEBOUNCE_N = 3,
  parameter int DATA_W     = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  output logic [1:0]        avm_address,
  output logic              avm_read,
  input  logic [31:0]       avm_readdata,
  output logic [DATA_W-1:0] buttons,
  output logic [DATA_W-1:0] pressed,
  output logic [DATA_W-1:0] released
);

  localparam int                PCNT_W   = cntr_width(POLL_DIV);
  localparam logic [PCNT_W-1:0] C_RELOAD = PCNT_W'(POLL_DIV - 1);

  poll_state_t       r_state;
  poll_state_t       w_state_next;
  logic [PCNT_W-1:0] r_poll_cnt;
  logic              r_avm_read;
  logic              w_sample_valid;
  logic              w_unused_rd;

  // Bits above DATA_W are not used; folding them here keeps them visibly
  // consumed without affecting any logic.
  assign w_unused_rd = &{1'b0, avm_readdata};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_sample_valid = 1'b0;
    case (r_state)
      IDLE: begin
        if (enable && (r_poll_cnt == '0)) begin
          w_state_next = READ;
        end
      end
      READ: begin
        // The read is already issued; it always completes even if enable drops.
        w_state_next = CAPTURE;
      end
      CAPTURE: begin
        w_sample_valid = 1'b1;
        w_state_next   = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // Poll divider: counts down in IDLE, held at the reload value while
  // disabled so a full interval elapses after enable returns.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_poll_cnt <= C_RELOAD;
    end else begin
      case (r_state)
        IDLE: begin
          if (!enable) begin
            r_poll_cnt <= C_RELOAD;
          end else if (r_poll_cnt != '0) begin
            r_poll_cnt <= r_poll_cnt - PCNT_W'(1);
          end
        end
        CAPTURE: r_poll_cnt <= C_RELOAD;
        default: r_poll_cnt <= r_poll_cnt;
      endcase
    end
  end

  // Registered strobe, high exactly while the FSM sits in READ.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_avm_read <= 1'b0;
    end else begin
      r_avm_read <= (w_state_next == READ);
    end
  end

  assign avm_address = 2'b00;
  assign avm_read    = r_avm_read;

  nios_system_button_debounce #(
    .DATA_W     (DATA_W),
    .DEBOUNCE_N (DEBOUNCE_N)
  ) u_debounce (
    .clk          (clk),
    .reset_n      (reset_n),
    .sample_valid (w_sample_valid),
    .sample       (avm_readdata[DATA_W-1:0]),
    .buttons      (buttons),
    .pressed      (pressed),
    .released     (released)
  );

endmodule
`default_nettype wire

// File: tb/tb_nios_system_button_poller.sv
`default_nettype none
// ============================================================================
// Module   : tb_nios_system_button_poller
// Purpose  : Directed self-checking bench. Instance A uses POLL_DIV=4,
//            DEBOUNCE_N=3; instance B uses POLL_DIV=1, DEBOUNCE_N=1 with the
//            unused readdata bits driven high. Each instance reads its PIO
//            sample sequence from a small table, one entry per read.
//            Cycle k = k-th clock period after reset release (cycle 0 first).
// Revision : 1.0 - initial release
// ============================================================================
module tb_nios_system_button_poller;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enA = 1'b1;
  logic        enB = 1'b1;
  logic [1:0]  addrA, addrB;
  logic        readA, readB;
  logic [31:0] rdA = '0;
  logic [31:0] rdB = '0;
  logic [3:0]  btnA, pA, rA, btnB, pB, rB;

  logic [3:0]  tabA [16];
  logic [3:0]  tabB [16];
  int          idxA = 0;
  int          idxB = 0;
  int          cyc = 0;

  int          n_cmp = 0;
  int          n_err = 0;

  int          evA_cyc[$];
  logic [3:0]  evA_p[$];
  logic [3:0]  evA_r[$];
  int          evB_cyc[$];
  logic [3:0]  evB_p[$];
  logic [3:0]  evB_r[$];
  int          nrdA = 0, nrdB = 0, firstA = -1, firstB = -1, dblA = 0, dblB = 0;
  logic        prevA = 1'b0, prevB = 1'b0;

  always #5 clk = ~clk;

  nios_system_button_poller #(.POLL_DIV(4), .DEBOUNCE_N(3), .DATA_W(4)) u_dut_a (
    .clk(clk), .reset_n(reset_n), .enable(enA), .avm_address(addrA), .avm_read(readA),
    .avm_readdata(rdA), .buttons(btnA), .pressed(pA), .released(rA)
  );

  nios_system_button_poller #(.POLL_DIV(1), .DEBOUNCE_N(1), .DATA_W(4)) u_dut_b (
    .clk(clk), .reset_n(reset_n), .enable(enB), .avm_address(addrB), .avm_read(readB),
    .avm_readdata(rdB), .buttons(btnB), .pressed(pB), .released(rB)
  );

  // Cycle counter and PIO models (one-cycle read latency, table per read).
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cyc  <= 0;
      idxA <= 0;
      idxB <= 0;
    end else begin
      cyc <= cyc + 1;
      if (readA) begin
        rdA  <= {28'h0, tabA[idxA]};
        idxA <= (idxA < 15) ? idxA + 1 : idxA;
      end
      if (readB) begin
        rdB  <= {28'hFFFFFFF, tabB[idxB]};
        idxB <= (idxB < 15) ? idxB + 1 : idxB;
      end
    end
  end

  // Monitor: logs pulse events and read strobes at the falling edge.
  always @(negedge clk) begin
    if (!reset_n) begin
      evA_cyc.delete(); evA_p.delete(); evA_r.delete();
      evB_cyc.delete(); evB_p.delete(); evB_r.delete();
      nrdA <= 0; nrdB <= 0; firstA <= -1; firstB <= -1;
      dblA <= 0; dblB <= 0; prevA <= 1'b0; prevB <= 1'b0;
    end else begin
      if ((pA != 4'h0) || (rA != 4'h0)) begin
        evA_cyc.push_back(cyc); evA_p.push_back(pA); evA_r.push_back(rA);
      end
      if ((pB != 4'h0) || (rB != 4'h0)) begin
        evB_cyc.push_back(cyc); evB_p.push_back(pB); evB_r.push_back(rB);
      end
      if (readA) begin
        nrdA <= nrdA + 1;
        if (firstA < 0) firstA <= cyc;
        if (prevA) dblA <= dblA + 1;
      end
      if (readB) begin
        nrdB <= nrdB + 1;
        if (firstB < 0) firstB <= cyc;
        if (prevB) dblB <= dblB + 1;
      end
      prevA <= readA;
      prevB <= readB;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Checks the n-th logged pulse event of instance A (b=0) or B (b=1).
  task automatic check_ev(input bit b, input int n, input int c, input logic [3:0] p,
                          input logic [3:0] r);
    int sz;
    sz = b ? evB_cyc.size() : evA_cyc.size();
    if (sz > n) begin
      check_val($sformatf("ev%s%0d_cyc", b ? "B" : "A", n), b ? evB_cyc[n] : evA_cyc[n], c);
      check_val($sformatf("ev%s%0d_prs", b ? "B" : "A", n), b ? evB_p[n] : evA_p[n], {28'h0, p});
      check_val($sformatf("ev%s%0d_rel", b ? "B" : "A", n), b ? evB_r[n] : evA_r[n], {28'h0, r});
    end else begin
      check_val($sformatf("ev%s%0d_present", b ? "B" : "A", n), sz, n + 1);
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    // ---------------- Phase 1: clean press (A), minimum parameters (B)
    for (int i = 0; i < 16; i++) begin
      tabA[i] = 4'hE;
      tabB[i] = 4'hC;
    end
    tabB[0] = 4'h7; tabB[1] = 4'h3; tabB[2] = 4'h3; tabB[3] = 4'hF;
    do_reset();
    #1;
    check_val("rst_readA", readA, 0);
    check_val("rst_addrA", addrA, 0);
    check_val("rst_btnA", btnA, 4'hF);
    check_val("rst_prsA", pA, 0);
    check_val("rst_relA", rA, 0);
    check_val("rst_btnB", btnB, 4'hF);
    repeat (40) @(negedge clk);
    #1;
    check_val("p1_firstA", firstA, 4);
    check_val("p1_evA_n", evA_cyc.size(), 1);
    check_ev(1'b0, 0, 18, 4'h1, 4'h0);
    check_val("p1_btnA", btnA, 4'hE);
    check_val("p1_dblA", dblA, 0);
    check_val("p1_firstB", firstB, 1);
    check_val("p1_nrdB", nrdB, 14);
    check_val("p1_evB_n", evB_cyc.size(), 4);
    check_ev(1'b1, 0, 3, 4'h8, 4'h0);
    check_ev(1'b1, 1, 6, 4'h4, 4'h0);
    check_ev(1'b1, 2, 12, 4'h0, 4'hC);
    check_ev(1'b1, 3, 15, 4'h3, 4'h0);
    check_val("p1_btnB", btnB, 4'hC);
    check_val("p1_dblB", dblB, 0);
    // Cycle 40 is a READ cycle for A; reset must drop the strobe at once.
    check_val("p1_readA_c40", readA, 1);
    #1 reset_n = 1'b0;
    #1;
    check_val("midrd_readA", readA, 0);
    check_val("midrd_btnA", btnA, 4'hF);
    check_val("midrd_prsA", pA, 0);

    // ---------------- Phase 2: bounce (A), enable handling (B)
    for (int i = 0; i < 16; i++) begin
      tabA[i] = 4'hE;
      tabB[i] = 4'h7;
    end
    tabA[1] = 4'hF;
    enB = 1'b0;
    do_reset();
    for (int k = 1; k <= 75; k++) begin
      @(negedge clk);
      if (k == 50) begin
        #1 check_val("p2_nrdB_dis", nrdB, 0);
        enB = 1'b1;
      end
      if (k == 51) enB = 1'b0;
      if (k == 70) begin
        #1 check_val("p2_nrdB_held", nrdB, 1);
        enB = 1'b1;
      end
    end
    #1;
    check_val("p2_firstA", firstA, 4);
    check_val("p2_evA_n", evA_cyc.size(), 1);
    check_ev(1'b0, 0, 30, 4'h1, 4'h0);
    check_val("p2_btnA", btnA, 4'hE);
    check_val("p2_firstB", firstB, 51);
    check_val("p2_evB_n", evB_cyc.size(), 1);
    check_ev(1'b1, 0, 53, 4'h8, 4'h0);
    check_val("p2_nrdB_end", nrdB, 3);

    // ---------------- Phase 3: release and simultaneous bits (A)
    for (int i = 0; i < 16; i++) begin
      tabA[i] = (i < 3) ? 4'hE : 4'h5;
      tabB[i] = 4'hF;
    end
    enB = 1'b1;
    do_reset();
    repeat (45) @(negedge clk);
    #1;
    check_val("p3_evA_n", evA_cyc.size(), 2);
    check_ev(1'b0, 0, 18, 4'h1, 4'h0);
    check_ev(1'b0, 1, 36, 4'hA, 4'h1);
    check_val("p3_btnA", btnA, 4'h5);
    check_val("p3_dblA", dblA, 0);
    check_val("p3_evB_n", evB_cyc.size(), 0);
    check_val("p3_btnB", btnB, 4'hF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
